re_stage_reg: RTL and testbench

Register-read/execute (RE) pipeline register for the 8-register pipelined RISC core. It captures the decoded instruction from the DR stage and presents the RE-stage fields that the forwarding unit and the execute stage consume: reg_efct_RE, flush_RE, load_RE, store_RE, Rs1_RE, Rs2_RE and Rd_RE. It also contains the load-use interlock. The forwarding unit can forward a load result only from MW, so this block stalls DR and inserts exactly one bubble whenever the instruction in DR depends on a load in RE. It keeps saturating counters of interlock and external-stall cycles.

---
 rtl/re_stage_reg_if.sv | 57 +++++
 rtl/re_stage_reg.sv | 131 +++++++++++++
 tb/tb_re_stage_reg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/re_stage_reg_if.sv
// rtl/re_stage_reg_if.sv - DR-to-RE stage bundle: decoded DR inputs, control, and RE-stage outputs
//
// Port summary:
//   DR side : flush_DR, reg_efct_DR[2:0], load_DR, store_DR, Rs1_DR/Rs2_DR/Rd_DR[2:0],
//             opA_DR/opB_DR[DATA_W], ctrl_DR[CTRL_W]
//   control : branch_kill, ext_stall
//   RE side : flush_RE, reg_efct_RE[2:0], load_RE, store_RE, Rs1_RE/Rs2_RE/Rd_RE[2:0],
//             opA_RE/opB_RE[DATA_W], ctrl_RE[CTRL_W]
//   status  : stall_DR, bubble_src[1:0], lu_count/xs_count[CNT_W]
// The slave modport is the pipeline register itself; master is the surrounding core.
interface re_stage_reg_if #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              flush_DR;
    logic [2:0]        reg_efct_DR;
    logic              load_DR;
    logic              store_DR;
    logic [2:0]        Rs1_DR;
    logic [2:0]        Rs2_DR;
    logic [2:0]        Rd_DR;
    logic [DATA_W-1:0] opA_DR;
    logic [DATA_W-1:0] opB_DR;
    logic [CTRL_W-1:0] ctrl_DR;
    logic              branch_kill;
    logic              ext_stall;

    logic              flush_RE;
    logic [2:0]        reg_efct_RE;
    logic              load_RE;
    logic              store_RE;
    logic [2:0]        Rs1_RE;
    logic [2:0]        Rs2_RE;
    logic [2:0]        Rd_RE;
    logic [DATA_W-1:0] opA_RE;
    logic [DATA_W-1:0] opB_RE;
    logic [CTRL_W-1:0] ctrl_RE;
    logic              stall_DR;
    logic [1:0]        bubble_src;
    logic [CNT_W-1:0]  lu_count;
    logic [CNT_W-1:0]  xs_count;

    modport slave (
        input  flush_DR, reg_efct_DR, load_DR, store_DR, Rs1_DR, Rs2_DR, Rd_DR,
               opA_DR, opB_DR, ctrl_DR, branch_kill, ext_stall,
        output flush_RE, reg_efct_RE, load_RE, store_RE, Rs1_RE, Rs2_RE, Rd_RE,
               opA_RE, opB_RE, ctrl_RE, stall_DR, bubble_src, lu_count, xs_count
    );

    modport master (
        output flush_DR, reg_efct_DR, load_DR, store_DR, Rs1_DR, Rs2_DR, Rd_DR,
               opA_DR, opB_DR, ctrl_DR, branch_kill, ext_stall,
        input  flush_RE, reg_efct_RE, load_RE, store_RE, Rs1_RE, Rs2_RE, Rd_RE,
               opA_RE, opB_RE, ctrl_RE, stall_DR, bubble_src, lu_count, xs_count
    );
endinterface

// File: rtl/re_stage_reg.sv
// rtl/re_stage_reg.sv - RE pipeline register with load-use interlock and stall counters
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; RE becomes a reset bubble, counters clear
//   bus    : re_stage_reg_if.slave carrying the DR inputs, branch_kill/ext_stall,
//            the registered RE fields, stall_DR (combinational), bubble_src and counters
//
// Edge priority: branch_kill > ext_stall > load-use hazard > normal capture.
module re_stage_reg #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    re_stage_reg_if.slave   bus
);
    typedef enum logic [1:0] {
        VALID     = 2'b00,
        RESET_BUB = 2'b01,
        LU_BUB    = 2'b10,
        KILL_BUB  = 2'b11
    } bsrc_e;

    logic              flush_q;
    logic [2:0]        efct_q;
    logic              load_q;
    logic              store_q;
    logic [2:0]        rs1_q;
    logic [2:0]        rs2_q;
    logic [2:0]        rd_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [CTRL_W-1:0] ctrl_q;
    bsrc_e             src_q;
    bsrc_e             src_d;
    logic [CNT_W-1:0]  lu_q;
    logic [CNT_W-1:0]  lu_d;
    logic [CNT_W-1:0]  xs_q;
    logic [CNT_W-1:0]  xs_d;
    logic              hz;
    logic              bubble_in;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        // Load in RE whose Rd is read by a real instruction in DR; the
        // forwarding unit can only supply load data from MW, so wait one cycle.
        hz = !flush_q & load_q & efct_q[0] & !bus.flush_DR &
             ((bus.reg_efct_DR[2] & (bus.Rs1_DR == rd_q)) |
              (bus.reg_efct_DR[1] & (bus.Rs2_DR == rd_q)));

        // A bubble is loaded on a kill, or on a hazard that ext_stall does not mask.
        bubble_in = bus.branch_kill | (!bus.ext_stall & hz);

        lu_d = (&lu_q) ? lu_q : lu_q + CNT_ONE;
        xs_d = (&xs_q) ? xs_q : xs_q + CNT_ONE;

        // A flushed DR slot keeps the reason the slot went empty; a flush
        // arriving right behind a valid instruction can only come from a kill.
        if (!bus.flush_DR)
            src_d = VALID;
        else if (src_q == VALID)
            src_d = KILL_BUB;
        else
            src_d = src_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q <= 1'b1;
            efct_q  <= 3'b000;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            rs1_q   <= 3'd0;
            rs2_q   <= 3'd0;
            rd_q    <= 3'd0;
            opa_q   <= '0;
            opb_q   <= '0;
            ctrl_q  <= '0;
            src_q   <= RESET_BUB;
            lu_q    <= '0;
            xs_q    <= '0;
        end else if (bubble_in) begin
            flush_q <= 1'b1;
            efct_q  <= 3'b000;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            rs1_q   <= 3'd0;
            rs2_q   <= 3'd0;
            rd_q    <= 3'd0;
            opa_q   <= '0;
            opb_q   <= '0;
            ctrl_q  <= '0;
            src_q   <= bus.branch_kill ? KILL_BUB : LU_BUB;
            if (!bus.branch_kill)
                lu_q <= lu_d;
        end else if (bus.ext_stall) begin
            xs_q <= xs_d;
        end else begin
            flush_q <= bus.flush_DR;
            efct_q  <= bus.reg_efct_DR;
            load_q  <= bus.load_DR;
            store_q <= bus.store_DR;
            rs1_q   <= bus.Rs1_DR;
            rs2_q   <= bus.Rs2_DR;
            rd_q    <= bus.Rd_DR;
            opa_q   <= bus.opA_DR;
            opb_q   <= bus.opB_DR;
            ctrl_q  <= bus.ctrl_DR;
            src_q   <= src_d;
        end
    end

    assign bus.flush_RE    = flush_q;
    assign bus.reg_efct_RE = efct_q;
    assign bus.load_RE     = load_q;
    assign bus.store_RE    = store_q;
    assign bus.Rs1_RE      = rs1_q;
    assign bus.Rs2_RE      = rs2_q;
    assign bus.Rd_RE       = rd_q;
    assign bus.opA_RE      = opa_q;
    assign bus.opB_RE      = opb_q;
    assign bus.ctrl_RE     = ctrl_q;
    assign bus.bubble_src  = src_q;
    assign bus.lu_count    = lu_q;
    assign bus.xs_count    = xs_q;
    // A kill empties DR anyway, so holding it would only waste a cycle.
    assign bus.stall_DR    = !bus.branch_kill & (bus.ext_stall | hz);
endmodule

// File: tb/tb_re_stage_reg.sv
// tb/tb_re_stage_reg.sv - self-checking bench for re_stage_reg
module tb_re_stage_reg;
    typedef struct packed {
        logic        flush;
        logic [2:0]  efct;
        logic        load;
        logic        store;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [2:0]  rd;
        logic [15:0] opa;
        logic [15:0] opb;
        logic [7:0]  ctrl;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    re_stage_reg_if #(.DATA_W(16), .CTRL_W(8), .CNT_W(16)) ifc ();
    re_stage_reg_if #(.DATA_W(16), .CTRL_W(8), .CNT_W(2))  ifs ();

    re_stage_reg #(.DATA_W(16), .CTRL_W(8), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));
    re_stage_reg #(.DATA_W(16), .CTRL_W(8), .CNT_W(2))  dut_s (.clk(clk), .reset(reset), .bus(ifs.slave));

    int checks = 0;
    int failures = 0;

    instr_t dr, m_re, bub;
    logic   bk, xs;
    int     m_src, m_lu, m_xs, m_lus;

    function automatic instr_t mk(logic f, logic [2:0] e, logic ld, logic st,
                                  logic [2:0] r1, logic [2:0] r2, logic [2:0] rd,
                                  logic [15:0] a, logic [15:0] b, logic [7:0] c);
        instr_t t;
        t.flush = f; t.efct = e; t.load = ld; t.store = st;
        t.rs1 = r1; t.rs2 = r2; t.rd = rd; t.opa = a; t.opb = b; t.ctrl = c;
        return t;
    endfunction

    function automatic instr_t dut_re();
        return {ifc.flush_RE, ifc.reg_efct_RE, ifc.load_RE, ifc.store_RE, ifc.Rs1_RE,
                ifc.Rs2_RE, ifc.Rd_RE, ifc.opA_RE, ifc.opB_RE, ifc.ctrl_RE};
    endfunction

    // A load in RE writing a register that the DR instruction actually reads.
    function automatic logic m_hz();
        return !m_re.flush && m_re.load && m_re.efct[0] && !dr.flush &&
               ((dr.efct[2] && dr.rs1 == m_re.rd) || (dr.efct[1] && dr.rs2 == m_re.rd));
    endfunction

    task automatic drive();
        ifc.flush_DR = dr.flush;  ifs.flush_DR = dr.flush;
        ifc.reg_efct_DR = dr.efct; ifs.reg_efct_DR = dr.efct;
        ifc.load_DR = dr.load;    ifs.load_DR = dr.load;
        ifc.store_DR = dr.store;  ifs.store_DR = dr.store;
        ifc.Rs1_DR = dr.rs1;      ifs.Rs1_DR = dr.rs1;
        ifc.Rs2_DR = dr.rs2;      ifs.Rs2_DR = dr.rs2;
        ifc.Rd_DR = dr.rd;        ifs.Rd_DR = dr.rd;
        ifc.opA_DR = dr.opa;      ifs.opA_DR = dr.opa;
        ifc.opB_DR = dr.opb;      ifs.opB_DR = dr.opb;
        ifc.ctrl_DR = dr.ctrl;    ifs.ctrl_DR = dr.ctrl;
        ifc.branch_kill = bk;     ifs.branch_kill = bk;
        ifc.ext_stall = xs;       ifs.ext_stall = xs;
        #1;
    endtask

    task automatic model_reset();
        m_re = bub; m_src = 1; m_lu = 0; m_xs = 0; m_lus = 0;
    endtask

    // Advance one clock edge and apply the per-edge priority rules to the model.
    task automatic tick();
        logic h;
        h = m_hz();
        @(posedge clk);
        if (bk) begin
            m_re = bub; m_src = 3;
        end else if (xs) begin
            if (m_xs < 65535) m_xs++;
        end else if (h) begin
            m_re = bub; m_src = 2;
            if (m_lu < 65535) m_lu++;
            if (m_lus < 3) m_lus++;
        end else begin
            if (!dr.flush) m_src = 0;
            else if (m_src == 0) m_src = 3;
            m_re = dr;
        end
        #1;
    endtask

    task automatic test_reset();
        dr = mk(0, 3'b101, 1, 0, 3'd1, 3'd0, 3'd4, 16'h5555, 16'h0, 8'h11);
        bk = 0; xs = 0; drive(); tick();
        xs = 1; drive(); tick();
        #2; reset = 1; xs = 0; drive(); model_reset();
        checks++; if (ifc.flush_RE !== 1'b1) begin failures++; $display("FAIL reset_flush got=%0b want=1", ifc.flush_RE); end
        checks++; if (ifc.bubble_src !== 2'b01) begin failures++; $display("FAIL reset_src got=%0b want=01", ifc.bubble_src); end
        checks++; if (ifc.lu_count !== 16'd0 || ifc.xs_count !== 16'd0) begin failures++; $display("FAIL reset_counts got lu=%0d xs=%0d want 0 0", ifc.lu_count, ifc.xs_count); end
        checks++; if (ifc.stall_DR !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b want=0", ifc.stall_DR); end
        checks++; if (dut_re() !== bub) begin failures++; $display("FAIL reset_fields got=%h want=%h", dut_re(), bub); end
        @(negedge clk); reset = 0;
    endtask

    task automatic test_pass_through();
        instr_t add;
        add = mk(0, 3'b101, 0, 0, 3'd2, 3'd0, 3'd3, 16'h1234, 16'h0, 8'h00);
        dr = add; bk = 0; xs = 0; drive(); tick();
        checks++; if (dut_re() !== add) begin failures++; $display("FAIL pass_fields got=%h want=%h", dut_re(), add); end
        checks++; if (ifc.bubble_src !== 2'b00) begin failures++; $display("FAIL pass_src got=%0b want=00", ifc.bubble_src); end
    endtask

    task automatic test_load_use();
        instr_t add;
        add = mk(0, 3'b011, 0, 0, 3'd0, 3'd4, 3'd5, 16'h0a0a, 16'h0b0b, 8'h22);
        dr = mk(0, 3'b101, 1, 0, 3'd1, 3'd0, 3'd4, 16'h0, 16'h0, 8'h33); drive(); tick();
        dr = add; drive();
        checks++; if (ifc.stall_DR !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b want=1", ifc.stall_DR); end
        tick();
        checks++; if (dut_re() !== bub || ifc.bubble_src !== 2'b10) begin failures++; $display("FAIL lu_bubble got=%h src=%0b want=%h src=10", dut_re(), ifc.bubble_src, bub); end
        checks++; if (ifc.lu_count !== 16'd1) begin failures++; $display("FAIL lu_count got=%0d want=1", ifc.lu_count); end
        checks++; if (ifc.stall_DR !== 1'b0) begin failures++; $display("FAIL lu_release got=%0b want=0", ifc.stall_DR); end
        tick();
        checks++; if (dut_re() !== add || ifc.bubble_src !== 2'b00) begin failures++; $display("FAIL lu_enter got=%h src=%0b want=%h src=00", dut_re(), ifc.bubble_src, add); end
        checks++; if (ifc.lu_count !== 16'd1) begin failures++; $display("FAIL lu_single got=%0d want=1", ifc.lu_count); end
    endtask

    task automatic test_no_hazard();
        dr = mk(0, 3'b101, 1, 0, 3'd1, 3'd0, 3'd4, 16'h0, 16'h0, 8'h0); drive(); tick();
        dr = mk(0, 3'b001, 0, 0, 3'd4, 3'd1, 3'd6, 16'h0, 16'h0, 8'h0); drive();
        checks++; if (ifc.stall_DR !== 1'b0) begin failures++; $display("FAIL nohz_a got=%0b want=0", ifc.stall_DR); end
        dr = mk(0, 3'b101, 0, 0, 3'd1, 3'd0, 3'd4, 16'h0, 16'h0, 8'h0); drive(); tick();
        dr = mk(0, 3'b111, 0, 0, 3'd4, 3'd4, 3'd6, 16'h0, 16'h0, 8'h0); drive();
        checks++; if (ifc.stall_DR !== 1'b0) begin failures++; $display("FAIL nohz_b got=%0b want=0", ifc.stall_DR); end
        tick();
    endtask

    task automatic test_stall_precedence();
        instr_t ld, st;
        int xs0, lu0;
        ld = mk(0, 3'b101, 1, 0, 3'd2, 3'd0, 3'd4, 16'h7777, 16'h0, 8'h44);
        st = mk(0, 3'b110, 0, 1, 3'd1, 3'd4, 3'd0, 16'h0, 16'h0, 8'h55);
        dr = ld; drive(); tick();
        xs0 = m_xs; lu0 = m_lu;
        dr = st; xs = 1; drive();
        for (int i = 0; i < 3; i++) begin
            checks++; if (ifc.stall_DR !== 1'b1) begin failures++; $display("FAIL xs_stall%0d got=%0b want=1", i, ifc.stall_DR); end
            tick();
            checks++; if (dut_re() !== ld || ifc.bubble_src !== 2'b00) begin failures++; $display("FAIL xs_hold%0d got=%h want=%h", i, dut_re(), ld); end
        end
        checks++; if (ifc.xs_count !== 16'(xs0 + 3) || ifc.lu_count !== 16'(lu0)) begin failures++; $display("FAIL xs_counts got xs=%0d lu=%0d want xs=%0d lu=%0d", ifc.xs_count, ifc.lu_count, xs0 + 3, lu0); end
        xs = 0; drive();
        checks++; if (ifc.stall_DR !== 1'b1) begin failures++; $display("FAIL xs_rehz got=%0b want=1", ifc.stall_DR); end
        tick();
        checks++; if (ifc.bubble_src !== 2'b10 || ifc.lu_count !== 16'(lu0 + 1)) begin failures++; $display("FAIL xs_bubble got src=%0b lu=%0d want src=10 lu=%0d", ifc.bubble_src, ifc.lu_count, lu0 + 1); end
        tick();
        checks++; if (dut_re() !== st || ifc.lu_count !== 16'(lu0 + 1)) begin failures++; $display("FAIL xs_enter got=%h lu=%0d want=%h lu=%0d", dut_re(), ifc.lu_count, st, lu0 + 1); end
    endtask

    task automatic test_kill();
        dr = mk(0, 3'b101, 1, 0, 3'd2, 3'd0, 3'd4, 16'h0, 16'h0, 8'h0); drive(); tick();
        dr = mk(0, 3'b100, 0, 0, 3'd4, 3'd0, 3'd1, 16'h0, 16'h0, 8'h0); xs = 1; bk = 1; drive();
        checks++; if (ifc.stall_DR !== 1'b0) begin failures++; $display("FAIL kill_stall got=%0b want=0", ifc.stall_DR); end
        tick();
        checks++; if (dut_re() !== bub || ifc.bubble_src !== 2'b11) begin failures++; $display("FAIL kill_bubble got=%h src=%0b want=%h src=11", dut_re(), ifc.bubble_src, bub); end
        bk = 0; xs = 0; dr.flush = 1; drive(); tick();
        checks++; if (ifc.flush_RE !== 1'b1 || ifc.bubble_src !== 2'b11) begin failures++; $display("FAIL kill_keep got flush=%0b src=%0b want 1 11", ifc.flush_RE, ifc.bubble_src); end
        dr.flush = 0; drive(); tick();
        dr.flush = 1; drive(); tick();
        checks++; if (ifc.bubble_src !== 2'b11) begin failures++; $display("FAIL flush_after_valid got=%0b want=11", ifc.bubble_src); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            dr = mk(0, 3'b101, 1, 0, 3'd0, 3'd0, 3'd4, 16'h0, 16'h0, 8'h0); drive(); tick();
            dr = mk(0, 3'b011, 0, 0, 3'd0, 3'd4, 3'd5, 16'h0, 16'h0, 8'h0); drive(); tick(); tick();
            checks++; if (ifs.lu_count !== 2'(m_lus)) begin failures++; $display("FAIL sat_step%0d got=%0d want=%0d", k, ifs.lu_count, m_lus); end
        end
        checks++; if (ifs.lu_count !== 2'd3) begin failures++; $display("FAIL sat_final got=%0d want=3", ifs.lu_count); end
    endtask

    task automatic test_random();
        logic exp_stall;
        for (int n = 0; n < 400; n++) begin
            dr = mk(($urandom % 5) == 0, 3'($urandom), ($urandom % 3) == 0, ($urandom % 4) == 0,
                    3'($urandom % 4), 3'($urandom % 4), 3'($urandom % 4),
                    16'($urandom), 16'($urandom), 8'($urandom));
            bk = ($urandom % 10) == 0;
            xs = ($urandom % 5) == 0;
            drive();
            exp_stall = !bk && (xs || m_hz());
            checks++; if (ifc.stall_DR !== exp_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%0b want=%0b", n, ifc.stall_DR, exp_stall); end
            tick();
            checks++; if (dut_re() !== m_re) begin failures++; $display("FAIL rnd_fields n=%0d got=%h want=%h", n, dut_re(), m_re); end
            checks++; if (ifc.bubble_src !== 2'(m_src)) begin failures++; $display("FAIL rnd_src n=%0d got=%0b want=%0d", n, ifc.bubble_src, m_src); end
            checks++; if (ifc.lu_count !== 16'(m_lu) || ifc.xs_count !== 16'(m_xs) || ifs.lu_count !== 2'(m_lus)) begin
                failures++; $display("FAIL rnd_counts n=%0d got lu=%0d xs=%0d lus=%0d want %0d %0d %0d", n, ifc.lu_count, ifc.xs_count, ifs.lu_count, m_lu, m_xs, m_lus);
            end
        end
        bk = 0; xs = 0;
    endtask

    initial begin
        bub = mk(1, 3'b000, 0, 0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 8'h0);
        dr = bub; bk = 0; xs = 0;
        reset = 1; drive(); model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        test_reset();
        test_pass_through();
        test_load_use();
        test_no_hazard();
        test_stall_precedence();
        test_kill();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
